cbz_cbnz: RTL and testbench

//  Control-word generator for the LEGv8 compare-and-branch instructions CBZ and CBNZ.
//  - Sits in the instruction decoder beside the other instruction-class generators.
//  - Decodes the 32-bit instruction plus the datapath zero flag into a registered 94-bit control word CW.
//  - CW is all-zero when the instruction is not CBZ/CBNZ, so the top-level decoder can OR class outputs.

---
 rtl/cbz_cbnz.sv | 112 +++++++++++
 tb/tb_cbz_cbnz.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cbz_cbnz.sv
// cbz_cbnz: control-word generator for the LEGv8 CBZ/CBNZ compare-and-branch
// instructions. It decodes the instruction word and the Rt zero flag into a
// 94-bit control word, registered with a one-cycle latency. The word is
// all-zero for any other instruction, so the top-level decoder can OR the
// outputs of all instruction classes together.
module cbz_cbnz #(
  parameter logic [7:0] CBZ_OPC  = 8'hB4,
  parameter logic [7:0] CBNZ_OPC = 8'hB5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i,
  input  logic        z,
  output logic [93:0] CW
);

  // Program-counter select codes driven on PS.
  localparam logic [1:0] PS_INC4   = 2'b01;
  localparam logic [1:0] PS_OFFSET = 2'b11;

  // ALU function: pass operand A through unchanged.
  localparam logic [4:0] FS_PASS_A = 5'b00100;

  // Widens the 19-bit word offset to a 64-bit signed constant.
  function automatic logic [63:0] sext_imm19(input logic [18:0] imm);
    sext_imm19 = {{45{imm[18]}}, imm};
  endfunction

  // Packs the individual fields into the control-word layout, MSB first.
  function automatic logic [93:0] pack_cw(
    input logic [4:0]  da,
    input logic [4:0]  sa,
    input logic [4:0]  sb,
    input logic [4:0]  fs,
    input logic [1:0]  ps,
    input logic [1:0]  en,
    input logic        reg_write,
    input logic        mem_write,
    input logic        pc_sel,
    input logic        b_sel,
    input logic        status_load,
    input logic [63:0] k,
    input logic        state
  );
    pack_cw = {da, sa, sb, fs, ps, en, reg_write, mem_write, pc_sel, b_sel,
               status_load, k, state};
  endfunction

  logic [7:0]  opc;
  logic [4:0]  rt;
  logic [18:0] imm19;
  logic        is_cbz;
  logic        is_cbnz;
  logic        match;
  logic        taken;
  logic [1:0]  ps;
  logic [93:0] cw_d;
  logic [93:0] cw_q;

  assign opc   = i[31:24];
  assign rt    = i[4:0];
  assign imm19 = i[23:5];

  // Classify the instruction and resolve the branch direction from z.
  always_comb begin
    is_cbz  = 1'b0;
    is_cbnz = 1'b0;
    if (opc == CBZ_OPC) begin
      is_cbz = 1'b1;
    end
    if (opc == CBNZ_OPC) begin
      is_cbnz = 1'b1;
    end
    match = is_cbz | is_cbnz;
    taken = (is_cbz & z) | (is_cbnz & ~z);
    ps    = taken ? PS_OFFSET : PS_INC4;
  end

  // Build the next control word; every field stays zero for non-branch words.
  always_comb begin
    cw_d = '0;
    if (match) begin
      cw_d = pack_cw(
        rt,                 // DA
        rt,                 // SA
        rt,                 // SB
        FS_PASS_A,          // FS
        ps,                 // PS
        2'b00,              // enable
        1'b0,               // regWrite
        1'b0,               // memWrite
        1'b0,               // PC_sel
        1'b0,               // B_sel
        1'b0,               // status_load
        sext_imm19(imm19),  // k, supplied whether or not the branch is taken
        1'b0                // state: single-state instruction
      );
    end
  end

  // Output register; an asserted (low) reset clears the word on the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cw_q <= '0;
    end else begin
      cw_q <= cw_d;
    end
  end

  assign CW = cw_q;

endmodule

// File: tb/tb_cbz_cbnz.sv
// tb_cbz_cbnz: table-driven and random checks of the CBZ/CBNZ control word,
// with expected words queued as stimulus is applied and popped one edge later.
module tb_cbz_cbnz;

  logic        clock;
  logic        reset;
  logic [31:0] i;
  logic        z;
  logic [93:0] CW;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst_n;
    logic [31:0] i;
    logic        z;
    logic [93:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [93:0] exp_q[$];
  string       name_q[$];

  cbz_cbnz dut (
    .clock (clock),
    .reset (reset),
    .i     (i),
    .z     (z),
    .CW    (CW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [93:0] pk(input logic [4:0] r, input logic [1:0] ps,
                                     input logic [63:0] k);
    pk = {r, r, r, 5'b00100, ps, 2'b00, 5'b00000, k, 1'b0};
  endfunction

  // Reference decoder written from the field description.
  function automatic logic [93:0] model(input logic [31:0] ii, input logic zz);
    logic [63:0] k;
    logic [1:0]  ps;
    logic        cbz;
    logic        cbnz;
    cbz  = (ii[31:24] == 8'hB4);
    cbnz = (ii[31:24] == 8'hB5);
    model = '0;
    if (cbz || cbnz) begin
      k = {{45{ii[23]}}, ii[23:5]};
      if ((cbz && zz) || (cbnz && !zz)) ps = 2'b11;
      else ps = 2'b01;
      model = pk(ii[4:0], ps, k);
    end
  endfunction

  task automatic check(input string nm, input logic [93:0] act, input logic [93:0] e);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, e);
  endtask

  // Drive one cycle of stimulus, then compare the queued expectation after the edge.
  task automatic apply(input logic r, input logic [31:0] ii, input logic zz,
                       input logic [93:0] e, input string nm);
    logic [93:0] ex;
    string       en;
    reset = r;
    i     = ii;
    z     = zz;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", nm, CW);
    end else begin
      ex = exp_q.pop_front();
      en = name_q.pop_front();
      check(en, CW, ex);
    end
  endtask

  task automatic check_field(input string nm, input logic [63:0] act, input logic [63:0] e);
    check(nm, {30'b0, act}, {30'b0, e});
  endtask

  localparam logic [31:0] W_CBZ  = 32'hB4AAAAA0;
  localparam logic [31:0] W_CBNZ = 32'hB5555541;
  localparam logic [63:0] K_CBZ  = 64'hFFFF_FFFF_FFFD_5555;
  localparam logic [63:0] K_CBNZ = 64'h0000_0000_0002_AAAA;

  initial begin
    logic [31:0] ri;
    logic        rz;
    logic [7:0]  opcs [6];
    opcs[0] = 8'hB4; opcs[1] = 8'hB5; opcs[2] = 8'hB6;
    opcs[3] = 8'hB3; opcs[4] = 8'h00; opcs[5] = 8'hB4;

    reset = 1'b0;
    i     = '0;
    z     = 1'b0;
    @(posedge clock);
    #1;

    vecs.push_back('{1'b0, W_CBZ,  1'b1, 94'b0,                    "reset_holds_zero"});
    vecs.push_back('{1'b1, W_CBZ,  1'b0, pk(5'd0, 2'b01, K_CBZ),   "cbz_not_taken"});
    vecs.push_back('{1'b1, W_CBNZ, 1'b0, pk(5'd1, 2'b11, K_CBNZ),  "cbnz_taken"});
    vecs.push_back('{1'b1, W_CBZ,  1'b1, pk(5'd0, 2'b11, K_CBZ),   "cbz_taken"});
    vecs.push_back('{1'b1, W_CBNZ, 1'b1, pk(5'd1, 2'b01, K_CBNZ),  "cbnz_not_taken"});
    vecs.push_back('{1'b1, 32'h0,  1'b0, 94'b0,                    "zero_word_z0"});
    vecs.push_back('{1'b1, 32'h0,  1'b1, 94'b0,                    "zero_word_z1"});
    vecs.push_back('{1'b1, 32'hB6000000, 1'b0, 94'b0,              "opc_b6_z0"});
    vecs.push_back('{1'b1, 32'hB6000000, 1'b1, 94'b0,              "opc_b6_z1"});
    vecs.push_back('{1'b1, 32'hB3FFFFFF, 1'b1, 94'b0,              "opc_b3"});
    vecs.push_back('{1'b1, {8'hB4, 19'h40000, 5'd31}, 1'b0,
                     pk(5'd31, 2'b01, 64'hFFFF_FFFF_FFFC_0000),    "k_most_negative"});
    vecs.push_back('{1'b1, {8'hB5, 19'h3FFFF, 5'd7}, 1'b0,
                     pk(5'd7, 2'b11, 64'h0000_0000_0003_FFFF),     "k_most_positive"});

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].rst_n, vecs[n].i, vecs[n].z, vecs[n].exp, vecs[n].name);
      if (n == 1) begin
        check_field("cbz_ps",       {62'b0, CW[73:72]}, 64'd1);
        check_field("cbz_sa",       {59'b0, CW[88:84]}, 64'd0);
        check_field("cbz_k",        CW[64:1], K_CBZ);
        check_field("cbz_regwrite", {63'b0, CW[69]}, 64'd0);
        check_field("cbz_state",    {63'b0, CW[0]}, 64'd0);
        n_checks++;
        if (CW != 94'b0) n_pass++;
        else $display("FAIL release_nonzero: got %h expected nonzero", CW);
      end
      if (n == 2) begin
        check_field("cbnz_ps",   {62'b0, CW[73:72]}, 64'd3);
        check_field("cbnz_regs", {49'b0, CW[93:79]}, {49'b0, 5'd1, 5'd1, 5'd1});
        check_field("cbnz_k",    CW[64:1], K_CBNZ);
        check_field("cbnz_mw",   {63'b0, CW[68]}, 64'd0);
      end
    end

    // Back-to-back words with a reset dropped into the middle of the stream.
    apply(1'b1, W_CBZ,  1'b0, pk(5'd0, 2'b01, K_CBZ),  "b2b_cbz");
    apply(1'b1, W_CBNZ, 1'b0, pk(5'd1, 2'b11, K_CBNZ), "b2b_cbnz");
    apply(1'b1, W_CBZ,  1'b1, pk(5'd0, 2'b11, K_CBZ),  "b2b_cbz_z1");
    apply(1'b0, W_CBNZ, 1'b0, 94'b0,                   "b2b_mid_reset");
    apply(1'b1, W_CBNZ, 1'b0, pk(5'd1, 2'b11, K_CBNZ), "b2b_after_reset");
    apply(1'b1, 32'h0,  1'b1, 94'b0,                   "b2b_to_zero");

    // Random words over the interesting opcodes, checked against the model.
    for (int n = 0; n < 60; n++) begin
      ri = $urandom;
      ri[31:24] = opcs[$urandom_range(0, 5)];
      if (n % 7 == 6) ri[31:24] = 8'($urandom);
      rz = 1'($urandom);
      apply(1'b1, ri, rz, model(ri, rz), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
